// File: rtl/rv_boot_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port of the boot loader.
// The master side is the loader, and the slave side is the byte source and memory.
interface rv_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wd
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wd
  );
endinterface

// File: rtl/rv_boot_loader.sv
// Boot controller: takes a 16-bit word count, then little-endian 32-bit words, writes them
// to consecutive instruction-memory addresses and releases the core from reset at PC 0.
module rv_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  rv_boot_loader_if.master  bus,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [ADDR_W:0]   WL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [1:0]        byte_cnt;
  logic [7:0]        n_lo;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       shift_word;
  logic [ADDR_W:0]   words_next;
  logic              accept;

  // A count is usable only if it is non-zero and fits in memory, so the index never wraps.
  function automatic logic hdr_valid(input logic [15:0] n);
    return (n != 16'd0) && ({1'b0, n} <= (17'd1 << ADDR_W));
  endfunction

  assign accept     = bus.rx_valid & bus.rx_ready;
  assign words_next = words_loaded + WL_ONE;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      byte_cnt     <= 2'd0;
      n_lo         <= 8'd0;
      n_words      <= '0;
      word_idx     <= '0;
      words_loaded <= '0;
      shift_word   <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            state        <= S_HDR;
            byte_cnt     <= 2'd0;
            word_idx     <= '0;
            words_loaded <= '0;
          end
        end
        S_HDR: begin
          if (accept) begin
            if (byte_cnt == 2'd0) begin
              n_lo     <= bus.rx_data;
              byte_cnt <= 2'd1;
            end else begin
              byte_cnt <= 2'd0;
              if (hdr_valid({bus.rx_data, n_lo})) begin
                n_words <= (ADDR_W+1)'({bus.rx_data, n_lo});
                state   <= S_LOAD;
              end else begin
                state   <= S_ERROR;
              end
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            shift_word[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          word_idx     <= word_idx + IDX_ONE;
          words_loaded <= words_next;
          state        <= (words_next == n_words) ? S_RUN : S_LOAD;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Every output is decoded from state or taken straight from a register.
  assign bus.rx_ready  = (state == S_HDR) || (state == S_LOAD);
  assign bus.imem_we   = (state == S_WRITE);
  assign bus.imem_addr = word_idx;
  assign bus.imem_wd   = shift_word;
  assign core_reset    = (state != S_RUN);
  assign busy          = (state == S_HDR) || (state == S_LOAD) || (state == S_WRITE);
  assign done          = (state == S_RUN);
  assign err           = (state == S_ERROR);

endmodule

// File: tb/tb_rv_boot_loader.sv
// Directed bench for rv_boot_loader: stream driver, write scoreboard and state checks.
module tb_rv_boot_loader;
  localparam int ADDR_W = 10;

  logic            clk = 1'b0;
  logic            Reset;
  logic            start;
  logic            core_reset;
  logic            busy;
  logic            done;
  logic            err;
  logic [ADDR_W:0] words_loaded;

  rv_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  rv_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .start        (start),
    .bus          (bus),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+31:0] sb [$];
  logic [ADDR_W+31:0] sb_item;
  logic prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every imem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      chk("we_not_back_to_back", 32'(prev_we), 32'd0);
      chk("rx_ready_in_write", 32'(bus.rx_ready), 32'd0);
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        sb_item = sb.pop_front();
        chk("write_addr", 32'(bus.imem_addr), 32'(sb_item[ADDR_W+31:32]));
        chk("write_data", bus.imem_wd, sb_item[31:0]);
      end
    end
    prev_we = bus.imem_we;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int  n    = 0;
    bit  sent = 1'b0;
    while (!sent) begin
      bus.rx_data  = b;
      bus.rx_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      sent = bus.rx_valid && bus.rx_ready;
      step();
      n++;
      if (!sent && n > 100) begin
        errors++;
        $display("FAIL byte_timeout: byte %h not accepted after %0d cycles, required acceptance", b, n);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "stream stalled, aborting");
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] addr, input bit stall);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], stall);
    end
    sb.push_back({addr, w});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    chk({tag, "_imem_wd"}, bus.imem_wd, 32'd0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    Reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    step();
    step();
    check_reset_vals("reset");
    Reset = 1'b0;
    step();
    chk("idle_rx_ready", 32'(bus.rx_ready), 32'd0);

    // Basic load
    do_start();
    chk("basic_hdr_busy", 32'(busy), 32'd1);
    chk("basic_hdr_rx_ready", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h00100013, 10'd0, 1'b0);
    chk("basic_we_first", 32'(bus.imem_we), 32'd1);
    send_word(32'h00200093, 10'd1, 1'b0);
    chk("basic_we_last", 32'(bus.imem_we), 32'd1);
    chk("basic_core_reset_in_write", 32'(core_reset), 32'd1);
    step();
    chk("basic_core_reset_released", 32'(core_reset), 32'd0);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_words_loaded", 32'(words_loaded), 32'd2);
    chk("basic_sb_empty", 32'(sb.size()), 32'd0);

    // Restart from RUN
    do_start();
    chk("restart_core_reset", 32'(core_reset), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_words_loaded", 32'(words_loaded), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'hDEADBEEF, 10'd0, 1'b0);
    step();
    chk("restart_done_end", 32'(done), 32'd1);
    chk("restart_words_loaded_end", 32'(words_loaded), 32'd1);

    // Stalled stream, with a start pulse while busy that must be ignored
    do_start();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h00100013, 10'd0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_ignored_busy", 32'(busy), 32'd1);
    chk("busy_start_ignored_words", 32'(words_loaded), 32'd1);
    send_word(32'h00200093, 10'd1, 1'b1);
    step();
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_words_loaded", 32'(words_loaded), 32'd2);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Bad headers: N=0 then N=1025
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("bad0_err", 32'(err), 32'd1);
    chk("bad0_core_reset", 32'(core_reset), 32'd1);
    chk("bad0_busy", 32'(busy), 32'd0);
    step();
    chk("bad0_err_holds", 32'(err), 32'd1);
    chk("bad0_rx_ready", 32'(bus.rx_ready), 32'd0);
    do_start();
    chk("bad0_recover_err", 32'(err), 32'd0);
    chk("bad0_recover_busy", 32'(busy), 32'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    chk("bad1025_err", 32'(err), 32'd1);
    chk("bad1025_we", 32'(bus.imem_we), 32'd0);

    // Full memory, N=1024
    do_start();
    chk("full_err_cleared", 32'(err), 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      send_word(32'(i), 10'(i), 1'b0);
    end
    chk("full_last_addr", 32'(bus.imem_addr), 32'd1023);
    chk("full_last_data", bus.imem_wd, 32'h000003FF);
    step();
    chk("full_words_loaded", 32'(words_loaded), 32'd1024);
    chk("full_done", 32'(done), 32'd1);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Reset after 2 bytes of word 3
    do_start();
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'hA0A0A0A0, 10'd0, 1'b0);
    send_word(32'hA1A1A1A1, 10'd1, 1'b0);
    send_word(32'hA2A2A2A2, 10'd2, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    Reset = 1'b1;
    step();
    check_reset_vals("midload");
    chk("midload_sb_empty", 32'(sb.size()), 32'd0);
    Reset = 1'b0;
    step();
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h11223344, 10'd0, 1'b0);
    step();
    chk("after_reset_done", 32'(done), 32'd1);
    chk("after_reset_words_loaded", 32'(words_loaded), 32'd1);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv_boot_loader.md
# rv_boot_loader

Boot controller for the single-cycle RV32I core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into consecutive instruction-memory locations, holding the core in reset while it loads. When the announced number of words has been written, it releases the core to run from PC = 0.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity 2^ADDR_W words (1024 = 4 KiB)
- clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset of this block
- start  in  1  load request, sampled in IDLE, RUN or ERROR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts byte; transfer = rx_valid & rx_ready at rising edge
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  ADDR_W  word address for the write
- imem_wd  out  32  write data
- core_reset  out  1  reset to core (PC register); high except in RUN
- busy  out  1  high in HDR, LOAD, WRITE
- done  out  1  high in RUN
- err  out  1  high in ERROR
- words_loaded  out  ADDR_W+1  words written since last start

## Operation
- States: IDLE, HDR, LOAD, WRITE, RUN, ERROR.
- **IDLE:**
  - rx_ready=0, core_reset=1.
  - start=1 → HDR.
  - On entry to HDR: clear byte counter, word counter, words_loaded and imem_addr.
- **HDR:**
  - rx_ready=1.
  - Accept 2 bytes, first = count N[7:0], second = N[15:8].
  - After the 2nd byte: N=0 or N>2^ADDR_W → ERROR; otherwise → LOAD.
- **LOAD:**
  - rx_ready=1.
  - Bytes fill the shift word little-endian: byte k of word goes to bits [8k+7:8k].
  - After the 4th byte → WRITE.
- **WRITE:**
  - Lasts exactly one cycle.
  - imem_we=1, imem_wd=assembled word, imem_addr=current word index, rx_ready=0.
  - Next cycle: word index +1 and words_loaded +1.
  - words_loaded==N → RUN; else → LOAD.
- **RUN:**
  - core_reset=0, done=1, rx_ready=0.
  - start=1 → HDR, with core_reset=1 from the next cycle.
  - Bytes arriving in RUN are not accepted.
- **ERROR:**
  - err=1, core_reset=1, rx_ready=0.
  - Exit only by start → HDR, or by Reset.
- **Widths and wrap:**
  - Word index is ADDR_W bits.
  - The N limit guarantees the index never wraps during a load.
  - words_loaded is ADDR_W+1 bits, so N=2^ADDR_W is representable.
- **start while busy:** ignored.
- **Reset mid-load:** abandons the partial word; memory contents already written are kept; state → IDLE.

## Timing
- **Reset values:** state IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wd=0, core_reset=1, busy=0, done=0, err=0, words_loaded=0.
- All outputs are registered or decoded from state only. No combinational path from rx_valid or start to any output.
- **Throughput:** with rx_valid held high, one word per 5 cycles (4 accept cycles + 1 WRITE cycle).
- **Release latency:** the cycle after the last WRITE is the first RUN cycle, so core_reset falls 1 cycle after the final imem_we.
- **Restart:** the cycle after start is sampled in RUN, core_reset=1 and state=HDR. The core's PC is back at 0 before any new write.
- **Stalls:** rx_valid low stalls indefinitely with no timeout. The partial word and counters hold.
- **imem_we:** never asserted outside WRITE; never asserted for 2 consecutive cycles.

## Test plan
- **Basic load:**
  - Stimulus: Reset, start, stream 02 00 | 13 00 10 00 | 93 00 20 00.
  - Required:
    - Write 0x00100013 @0, then 0x00200093 @1.
    - words_loaded=2.
    - core_reset falls 1 cycle after the 2nd imem_we; done=1.
- **Stalled stream:**
  - Stimulus: same stream with rx_valid toggled randomly 50%.
  - Required:
    - Identical writes and addresses.
    - No write until all 4 bytes are accepted.
    - rx_ready=0 in every WRITE cycle.
- **Bad header:**
  - Stimulus: header 00 00, and separately 01 04 (N=1025).
  - Required:
    - err=1, no imem_we, core_reset=1.
    - start → HDR, err clears.
- **Full memory:**
  - Stimulus: N=1024, words = index value.
  - Required:
    - Last write is addr 1023, data 0x000003FF.
    - words_loaded=1024, then RUN.
- **Reset mid-load:**
  - Stimulus: Reset after 2 bytes of word 3.
  - Required:
    - Next cycle all outputs hold reset values.
    - A new start with N=1 writes addr 0.
- **Restart from RUN:**
  - Stimulus: start while done=1, load N=1, word 0xDEADBEEF.
  - Required:
    - core_reset=1 the next cycle.
    - Write @0 = 0xDEADBEEF.
    - words_loaded restarts at 0 and ends at 1.
